trig_scheduler: RTL
===================

TRIG_SCHEDULER -- requirements
Module: trig_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 8: number of trigger-condition requesters (power of 2, maximum 16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: trigger-record FIFO entries (power of 2).
REQ-003 SHALL have port clk_adc  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req  in  NREQ  level trigger-condition requests, one per trigger algorithm.
REQ-006 SHALL have port req_mask  in  NREQ  1 = requester enabled.
REQ-007 SHALL have port busy  in  1  downstream DAQ busy, active-high veto.
REQ-008 SHALL have port randnum  in  32  random word for prescale.
REQ-009 SHALL have port prescale  in  32  accept when randnum <= prescale.
REQ-010 SHALL have port pulse_len  in  8  output pulse width in clocks; 0 means 1.
REQ-011 SHALL have port dead_time  in  8  clocks of dead time after the pulse.
REQ-012 SHALL have port trig_out  out  1  registered trigger pulse.
REQ-013 SHALL have port trig_id  out  log2(NREQ)  index of the last granted requester.
REQ-014 SHALL have port timestamp  out  56  free-running clock counter.
REQ-015 SHALL have ports rec_valid  out  1,  rec_ready  in  1,  rec_id  out  log2(NREQ),  rec_time  out  56  for the trigger-record FIFO head.
REQ-016 SHALL have ports fire_count  out  32,  veto_count  out  32,  overflow  out  1 (sticky).

Function
REQ-017 SHALL implement the FSM states IDLE, FIRE and DEAD.
REQ-018 Round-robin pointer ptr: in IDLE, the candidate set is req & req_mask.
- Grant goes to the first set bit at or after ptr, wrapping modulo NREQ.
- On any grant decision, ptr SHALL become grant+1 (mod NREQ).
REQ-019 IDLE, candidate present, busy=0, randnum<=prescale (all sampled at edge N):
- From edge N+1: trig_out=1, trig_id=grant, state=FIRE.
- fire_count increments.
- Record {grant, timestamp value at edge N} is pushed.
REQ-020 IDLE, candidate present, with busy=1 or prescale failing:
- No fire; state stays IDLE.
- veto_count increments once per such cycle.
- ptr advances only on a prescale failure, not on a busy veto.
REQ-021 FIRE: pulse_len and dead_time are latched on entry; trig_out SHALL stay high exactly max(pulse_len,1) cycles. Exit:
- If latched dead_time > 0: go to DEAD.
- Otherwise: go to IDLE.
REQ-022 DEAD: trig_out=0 for exactly the latched dead_time cycles, then IDLE.
- With dead_time=0, the minimum spacing between pulse rising edges is pulse_len+1 clocks, because one IDLE sampling cycle is required.
REQ-023 Requests during FIRE/DEAD SHALL be ignored: no grant, no veto count, ptr unchanged.
REQ-024 FIFO behaviour:
- rec_valid = not empty; rec_id/rec_time present the oldest entry.
- A pop occurs when rec_valid & rec_ready.
- A push is accepted if not full, or if full with a pop in the same cycle.
- When full with no pop, the record is dropped, overflow is set, and the trigger still fires.
REQ-025 Wrap rules: timestamp, fire_count and veto_count wrap modulo 2^width; no saturation.
REQ-026 Input changes to pulse_len/dead_time mid-FIRE/DEAD SHALL not affect the current trigger.

Reset
REQ-027 rst=1 at an edge SHALL, at that edge, set:
- state=IDLE, trig_out=0, trig_id=0, ptr=0;
- timestamp=0, fire_count=0, veto_count=0, overflow=0;
- FIFO empty (rec_valid=0).
This applies regardless of state, including mid-pulse.
REQ-028 The first grant SHALL be possible on the first edge after rst deasserts.

Verification
REQ-029 req=0x01, mask=0xFF, prescale=0xFFFFFFFF, pulse_len=4, dead_time=3, held high: trig_out high 4 clocks, low 4, repeating; fire_count +1 per 8 clocks.
REQ-030 req=0x81 held, pulse_len=1, dead_time=0: trig_id alternates 0,7,0,7; rec FIFO holds ids in that order.
REQ-031 busy=1 for 10 clocks with req=0x04: no trig_out, veto_count=10; busy drops -> pulse 1 clock later, trig_id=2.
REQ-032 prescale=0, randnum=5 with req=0x02: no fire, veto_count counts; set randnum=0 -> fire, trig_id=1.
REQ-033 rec_ready=0, 5 fires with FIFO_DEPTH=4: rec_valid=1, 4 records kept, overflow=1; then rec_ready=1 drains records in order with their timestamps.
REQ-034 rst asserted during 3rd cycle of a pulse_len=8 pulse: trig_out=0 the next cycle, all counters 0, rec_valid=0.

Source files
------------

// File: rtl/trig_scheduler.sv
// Trigger scheduler: round-robin arbitration over masked trigger requests,
// prescale/busy vetoing, fixed-width pulse with dead time, and a record FIFO.
module trig_scheduler #(
  parameter int NREQ       = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk_adc,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_mask,
  input  logic            busy,
  input  logic [31:0]     randnum,
  input  logic [31:0]     prescale,
  input  logic [7:0]      pulse_len,
  input  logic [7:0]      dead_time,
  output logic            trig_out,
  output logic [IDW-1:0]  trig_id,
  output logic [55:0]     timestamp,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [IDW-1:0]  rec_id,
  output logic [55:0]     rec_time,
  output logic [31:0]     fire_count,
  output logic [31:0]     veto_count,
  output logic            overflow
);

  // state | meaning
  // IDLE  | sampling candidates; grant, veto or wait
  // FIRE  | trig_out high, r_cnt counts down the latched pulse width
  // DEAD  | trig_out low, r_cnt counts down the latched dead time
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t         r_state;
  logic [7:0]     r_cnt;
  logic [7:0]     r_dead;
  logic [IDW-1:0] r_ptr;
  logic           r_trig_out;
  logic [IDW-1:0] r_trig_id;
  logic [55:0]    r_ts;
  logic [31:0]    r_fire_cnt;
  logic [31:0]    r_veto_cnt;
  logic           r_ovf;

  logic [IDW-1:0] r_mem_id [FIFO_DEPTH];
  logic [55:0]    r_mem_ts [FIFO_DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [CW-1:0]  r_count;

  logic [NREQ-1:0] w_cand;
  logic            w_any;
  logic [IDW-1:0]  w_grant;
  logic            w_pre_ok;
  logic            w_idle;
  logic            w_fire;
  logic            w_veto;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;

  assign w_cand   = req & req_mask;
  assign w_pre_ok = (randnum <= prescale);
  assign w_idle   = (r_state == S_IDLE);

  // First candidate at or after r_ptr; NREQ is a power of two so the
  // index wraps naturally in IDW bits.
  always_comb begin
    logic [IDW-1:0] idx;
    w_any   = 1'b0;
    w_grant = '0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = r_ptr + IDW'(i);
      if (!w_any && w_cand[idx]) begin
        w_any   = 1'b1;
        w_grant = idx;
      end
    end
  end

  assign w_fire  = w_idle & w_any & ~busy & w_pre_ok;
  assign w_veto  = w_idle & w_any & (busy | ~w_pre_ok);

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & rec_ready;
  assign w_push  = w_fire & (~w_full | w_pop);

  function automatic logic [AW-1:0] f_nxt(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_adc) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dead     <= '0;
      r_ptr      <= '0;
      r_trig_out <= 1'b0;
      r_trig_id  <= '0;
      r_ts       <= '0;
      r_fire_cnt <= '0;
      r_veto_cnt <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_state    <= S_FIRE;
            r_trig_out <= 1'b1;
            r_trig_id  <= w_grant;
            r_ptr      <= w_grant + 1'b1;
            r_fire_cnt <= r_fire_cnt + 1'b1;
            r_cnt      <= (pulse_len == 8'd0) ? 8'd0 : pulse_len - 8'd1;
            r_dead     <= dead_time;
          end else if (w_veto) begin
            r_veto_cnt <= r_veto_cnt + 1'b1;
            // a busy veto keeps the pointer so the same requester retries
            if (!busy) r_ptr <= w_grant + 1'b1;
          end
        end
        S_FIRE: begin
          if (r_cnt == 8'd0) begin
            r_trig_out <= 1'b0;
            if (r_dead != 8'd0) begin
              r_state <= S_DEAD;
              r_cnt   <= r_dead - 8'd1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_DEAD: begin
          if (r_cnt == 8'd0) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_adc) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= f_nxt(r_wr);
      if (w_pop)  r_rd <= f_nxt(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_fire && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk_adc) begin
    if (w_push) begin
      r_mem_id[r_wr] <= w_grant;
      r_mem_ts[r_wr] <= r_ts;
    end
  end

  assign trig_out   = r_trig_out;
  assign trig_id    = r_trig_id;
  assign timestamp  = r_ts;
  assign fire_count = r_fire_cnt;
  assign veto_count = r_veto_cnt;
  assign overflow   = r_ovf;
  assign rec_valid  = ~w_empty;
  assign rec_id     = r_mem_id[r_rd];
  assign rec_time   = r_mem_ts[r_rd];

endmodule
